// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: packed-BCD to binary converter, one reverse double-dabble step per clock with valid/ready handshake
module bcd2bin_seq #(
  parameter int DIGITS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [4*DIGITS-1:0]                 in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(10**DIGITS)-1:0]       out_data,
  output logic                                out_err
);
  localparam int BIN_W = $clog2(10**DIGITS);
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state;
  logic [4*DIGITS-1:0] bcd, bcd_nx;
  logic [BIN_W-1:0] bin, bin_nx;
  logic [4*DIGITS+BIN_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic err, bad;
  always_comb begin
    sh = {bcd, bin} >> 1;
    bin_nx = sh[BIN_W-1:0];
    bcd_nx = sh[BIN_W +: 4*DIGITS];
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_nx[4*i +: 4] = bcd_nx[4*i +: 4] >= 4'd8 ? bcd_nx[4*i +: 4] - 4'd3 : bcd_nx[4*i +: 4];
      bad = bad | (in_data[4*i +: 4] > 4'd9);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
      cnt <= '0;
      bcd <= '0;
      bin <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          bcd <= in_data;
          bin <= '0;
          cnt <= '0;
          err <= bad;
          in_ready <= 1'b0;
          state <= CONV;
        end
        CONV: begin
          bcd <= bcd_nx;
          bin <= bin_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_data <= err ? '0 : bin_nx;
            out_err <= err;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: randomized and directed checks of bcd2bin_seq against an arithmetic BCD model
module tb_bcd2bin_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_err;
  logic [13:0] out_data;
  logic s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [3:0] s_in_data = '0;
  logic s_in_ready, s_out_valid, s_out_err;
  logic [3:0] s_out_data;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  bcd2bin_seq #(.DIGITS(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );
  bcd2bin_seq #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_err(s_out_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic void model(input logic [15:0] d, input int nd, output int v, output int e);
    v = 0;
    e = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      int dig;
      dig = int'((d >> (4 * i)) & 16'hF);
      if (dig > 9) e = 1;
      v = v * 10 + dig;
    end
    if (e != 0) v = 0;
  endfunction
  task automatic convert(input logic [15:0] d, input int stall);
    int n, ev, ee;
    model(d, 4, ev, ee);
    in_data = d;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    check("ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("ready_busy", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("latency", n, 14);
    check("data", out_data, ev);
    check("err", out_err, ee);
    for (int k = 0; k < stall; k++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, ev);
      check("hold_err", out_err, ee);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready, 1);
    check("drain_data_kept", out_data, ev);
  endtask
  initial begin
    int n, ev, ee;
    logic [15:0] d;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    convert(16'h1234, 0);
    convert(16'h12A4, 0);
    convert(16'hF000, 0);
    convert(16'h9999, 5);
    convert(16'h0000, 0);
    // back-to-back with in_valid held: second accept waits for the drain
    in_data = 16'h9999;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_data = 16'h0000;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("b2b_lat", n, 14);
    check("b2b_first", out_data, 9999);
    tick();
    n = 1;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("b2b_spacing", n, 16);
    check("b2b_second", out_data, 0);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("b2b_idle", in_ready, 1);
    convert(16'h1234, 0);
    in_data = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    convert(16'h0042, 0);
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) d = 16'($urandom);
      else for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      convert(d, int'($urandom_range(0, 3)));
    end
    for (int v = 0; v < 16; v++) begin
      model(16'(v), 1, ev, ee);
      s_in_data = 4'(v);
      s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
      n = 0;
      while (!s_out_valid && n < 20) begin tick(); n++; end
      check("d1_latency", n, 4);
      check("d1_data", s_out_data, ev);
      check("d1_err", s_out_err, ee);
      tick();
      check("d1_drain", s_in_ready, 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential packed-BCD to binary converter; it is the inverse of the team's combinational binary-to-BCD block.
- Algorithm is reverse double dabble, one shift/correct step per clock, so area stays small for wide digit counts.
- Sits between BCD sources (display/keypad/decimal register paths) and binary datapaths.
- Valid/ready handshake on both sides; flags any nibble > 9 as an error.

Parameters:
- DIGITS, 4, number of BCD digits on the input (>= 1).
- BIN_W, localparam = $clog2(10**DIGITS), binary output width (14 for DIGITS=4, 4 for DIGITS=1).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a new operand.
- in_data  input  4*DIGITS  packed BCD; digit 0 is at [3:0].
- out_valid  output  1  out_data and out_err are valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  BIN_W  binary result.
- out_err  output  1  at least one input nibble was > 9.

Behaviour:
- Reset: rst sampled high on an edge forces the following state. It overrides all other inputs, including in the middle of a conversion.
  - FSM = IDLE; in_ready=1; out_valid=0; out_data=0; out_err=0.
  - Step counter = 0; internal BCD/binary shift registers = 0.
  - An in-flight conversion is discarded and no result is emitted.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, capture in_data into the BCD register and clear the binary register and counter.
  - Latch err = OR over all digits of (nibble > 9). Go to CONV.
- CONV:
  - in_ready=0. Each edge performs one step.
  - Step: shift {bcd_reg, bin_reg} right by 1 (bcd LSB enters bin MSB), then subtract 3 from every 4-bit BCD digit whose post-shift value is >= 8. All digits are corrected in parallel within the same cycle.
  - Counter increments per step. The edge performing step BIN_W moves to DONE and loads the outputs:
    - out_data = bin_reg, or 0 if err;
    - out_err = err.
- DONE:
  - out_valid=1; in_ready=0; out_data and out_err held stable.
  - On an edge with out_ready=1, go to IDLE with out_valid=0. out_data and out_err keep their values until the next load.
  - With out_ready=0 the block stays in DONE indefinitely.
- Latency: out_valid rises BIN_W edges after the accepting edge (14 cycles for DIGITS=4).
- Throughput: one conversion per BIN_W+2 cycles with out_ready held high (accept, BIN_W steps, drain).
- in_ready depends only on state; it is never combinationally dependent on in_valid or out_ready.
- in_data and in_valid are ignored outside IDLE. No input buffering.
- Arithmetic rules:
  - Digit corrections are modulo 4 bits; valid input never underflows.
  - With invalid digits the internal result is undefined, so out_data is forced to 0 and out_err=1.
- Boundaries:
  - All-zero input gives out_data=0 after the full BIN_W steps (no early exit).
  - Maximum input (all 9s) gives 10**DIGITS-1, which fits BIN_W.

Test Plan:
- DIGITS=4, in_data=16'h1234, out_ready=1 -> out_valid rises 14 cycles after acceptance; out_data=14'd1234 (0x04D2), out_err=0; in_ready back to 1 next cycle.
- in_data=16'h9999 then 16'h0000 back-to-back, in_valid held -> out_data=9999 (0x270F) then 0; second operand accepted only after the first result drains; spacing 16 cycles.
- in_data=16'h12A4 -> out_err=1, out_data=0. in_data=16'hF000 -> out_err=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_data and out_err stable, in_ready=0; release -> one handshake, then IDLE.
- Reset mid-CONV (rst at step 6 of 16'h5678) -> next cycle in_ready=1, out_valid=0, out_data=0; new operand 16'h0042 then converts to 42 with no trace of 5678.
- DIGITS=1 build: in_data=4'h7 -> out_data=4'd7 after 4 cycles; in_data=4'hA -> out_err=1.
